// File: rtl/kbdmus_spi_rx.sv
// SPI receiver for AVR keyboard/mouse frames: decodes a command byte, then loads kbd_out or mus_out with a strobe.
// Joystick command 0x30 is enabled by defining KBDMUS_RX_KJOY_EN.
module kbdmus_spi_rx (
   input  logic        fclk,
   input  logic        rst_n,
   input  logic        spics_n,
   input  logic        spick,
   input  logic        spido,
   output logic [39:0] kbd_out,
   output logic        kbd_stb,
   output logic [7:0]  mus_out,
   output logic        mus_xstb,
   output logic        mus_ystb,
   output logic        mus_btnstb,
   output logic        kj_stb
);

   localparam int unsigned BYTE_W   = 8;
   localparam int unsigned SHADOW_W = 32;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_CMD  = 3'd1;
   localparam logic [2:0] ST_KBD  = 3'd2;
   localparam logic [2:0] ST_MUS  = 3'd3;
   localparam logic [2:0] ST_SKIP = 3'd4;

   localparam logic [1:0] TGT_X   = 2'd0;
   localparam logic [1:0] TGT_Y   = 2'd1;
   localparam logic [1:0] TGT_BTN = 2'd2;
`ifdef KBDMUS_RX_KJOY_EN
   localparam logic [1:0] TGT_KJ  = 2'd3;
`endif

   logic              cs_s1, cs_s2, cs_h;
   logic              ck_s1, ck_s2, ck_h;
   logic              do_s1, do_s2;
   logic [2:0]        fill;
   logic              armed;
   logic              cs_fall, ck_rise;

   logic              rise_q, mosi_q, done, byte_rdy;
   logic [BYTE_W-1:0] sr;
   logic [2:0]        cnt;

   logic [2:0]          state, state_nxt;
   logic [2:0]          kidx, kidx_nxt;
   logic [1:0]          tgt, tgt_nxt;
   logic [SHADOW_W-1:0] shadow, shadow_nxt;
   logic [39:0]         kbd_out_nxt;
   logic [7:0]          mus_out_nxt;
   logic                kbd_stb_nxt, mus_xstb_nxt, mus_ystb_nxt, mus_btnstb_nxt;
`ifdef KBDMUS_RX_KJOY_EN
   logic                kj_stb_nxt;
`endif

   // Synchronizers; armed blocks a false CS falling edge seen while the chain refills after reset
   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         cs_s1 <= 1'b1;
         cs_s2 <= 1'b1;
         cs_h  <= 1'b1;
         ck_s1 <= 1'b0;
         ck_s2 <= 1'b0;
         ck_h  <= 1'b0;
         do_s1 <= 1'b0;
         do_s2 <= 1'b0;
         fill  <= 3'b000;
         armed <= 1'b0;
      end else begin
         cs_s1 <= spics_n;
         cs_s2 <= cs_s1;
         cs_h  <= cs_s2;
         ck_s1 <= spick;
         ck_s2 <= ck_s1;
         ck_h  <= ck_s2;
         do_s1 <= spido;
         do_s2 <= do_s1;
         fill  <= {fill[1:0], 1'b1};
         if (fill[2] && cs_h)
            armed <= 1'b1;
      end
   end

   assign cs_fall = cs_h & ~cs_s2;
   assign ck_rise = ck_s2 & ~ck_h & ~cs_s2;

   // Byte assembly; fixed pipeline depth keeps strobe latency constant
   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         rise_q   <= 1'b0;
         mosi_q   <= 1'b0;
         sr       <= '0;
         cnt      <= 3'd0;
         done     <= 1'b0;
         byte_rdy <= 1'b0;
      end else if (cs_s2) begin
         rise_q   <= 1'b0;
         cnt      <= 3'd0;
         done     <= 1'b0;
         byte_rdy <= 1'b0;
      end else begin
         rise_q   <= ck_rise;
         mosi_q   <= do_s2;
         done     <= 1'b0;
         byte_rdy <= done;
         if (rise_q) begin
            sr   <= {sr[BYTE_W-2:0], mosi_q};
            cnt  <= cnt + 3'd1;
            done <= (cnt == 3'd7);
         end
      end
   end

   // Frame decoder next-state and output computation
   always_comb begin
      state_nxt      = state;
      kidx_nxt       = kidx;
      tgt_nxt        = tgt;
      shadow_nxt     = shadow;
      kbd_out_nxt    = kbd_out;
      mus_out_nxt    = mus_out;
      kbd_stb_nxt    = 1'b0;
      mus_xstb_nxt   = 1'b0;
      mus_ystb_nxt   = 1'b0;
      mus_btnstb_nxt = 1'b0;
`ifdef KBDMUS_RX_KJOY_EN
      kj_stb_nxt     = 1'b0;
`endif
      if (cs_s2) begin
         state_nxt  = ST_IDLE;
         kidx_nxt   = 3'd0;
         shadow_nxt = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cs_fall && armed)
                  state_nxt = ST_CMD;
            end
            ST_CMD: begin
               if (byte_rdy) begin
                  case (sr)
                     8'h10: begin
                        state_nxt = ST_KBD;
                        kidx_nxt  = 3'd0;
                     end
                     8'h20: begin
                        state_nxt = ST_MUS;
                        tgt_nxt   = TGT_X;
                     end
                     8'h21: begin
                        state_nxt = ST_MUS;
                        tgt_nxt   = TGT_Y;
                     end
                     8'h22: begin
                        state_nxt = ST_MUS;
                        tgt_nxt   = TGT_BTN;
                     end
`ifdef KBDMUS_RX_KJOY_EN
                     8'h30: begin
                        state_nxt = ST_MUS;
                        tgt_nxt   = TGT_KJ;
                     end
`endif
                     default: state_nxt = ST_SKIP;
                  endcase
               end
            end
            ST_KBD: begin
               if (byte_rdy) begin
                  case (kidx)
                     3'd0: shadow_nxt[7:0]   = sr;
                     3'd1: shadow_nxt[15:8]  = sr;
                     3'd2: shadow_nxt[23:16] = sr;
                     3'd3: shadow_nxt[31:24] = sr;
                     default: begin
                        kbd_out_nxt = {sr, shadow};
                        kbd_stb_nxt = 1'b1;
                        shadow_nxt  = '0;
                        state_nxt   = ST_SKIP;
                     end
                  endcase
                  kidx_nxt = kidx + 3'd1;
               end
            end
            ST_MUS: begin
               if (byte_rdy) begin
                  mus_out_nxt = sr;
                  state_nxt   = ST_SKIP;
                  case (tgt)
                     TGT_X:   mus_xstb_nxt   = 1'b1;
                     TGT_Y:   mus_ystb_nxt   = 1'b1;
                     TGT_BTN: mus_btnstb_nxt = 1'b1;
                     default: begin
`ifdef KBDMUS_RX_KJOY_EN
                        kj_stb_nxt = 1'b1;
`endif
                     end
                  endcase
               end
            end
            ST_SKIP: state_nxt = ST_SKIP;
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         kidx       <= 3'd0;
         tgt        <= TGT_X;
         shadow     <= '0;
         kbd_out    <= 40'h0;
         mus_out    <= 8'hFF;
         kbd_stb    <= 1'b0;
         mus_xstb   <= 1'b0;
         mus_ystb   <= 1'b0;
         mus_btnstb <= 1'b0;
      end else begin
         state      <= state_nxt;
         kidx       <= kidx_nxt;
         tgt        <= tgt_nxt;
         shadow     <= shadow_nxt;
         kbd_out    <= kbd_out_nxt;
         mus_out    <= mus_out_nxt;
         kbd_stb    <= kbd_stb_nxt;
         mus_xstb   <= mus_xstb_nxt;
         mus_ystb   <= mus_ystb_nxt;
         mus_btnstb <= mus_btnstb_nxt;
      end
   end

`ifdef KBDMUS_RX_KJOY_EN
   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n)
         kj_stb <= 1'b0;
      else
         kj_stb <= kj_stb_nxt;
   end
`else
   assign kj_stb = 1'b0;
`endif

endmodule

// File: tb/tb_kbdmus_spi_rx.sv
// Directed bench for kbdmus_spi_rx: table of SPI frames with expected strobes/outputs plus hand-written corner sequences.
module tb_kbdmus_spi_rx;

`ifdef KBDMUS_RX_KJOY_EN
   localparam bit KJ = 1'b1;
`else
   localparam bit KJ = 1'b0;
`endif
   localparam int HALF = 43;

   logic        fclk = 1'b0;
   logic        rst_n, spics_n, spick, spido;
   logic [39:0] kbd_out;
   logic [7:0]  mus_out;
   logic        kbd_stb, mus_xstb, mus_ystb, mus_btnstb, kj_stb;

   kbdmus_spi_rx dut (
      .fclk(fclk), .rst_n(rst_n), .spics_n(spics_n), .spick(spick), .spido(spido),
      .kbd_out(kbd_out), .kbd_stb(kbd_stb), .mus_out(mus_out),
      .mus_xstb(mus_xstb), .mus_ystb(mus_ystb), .mus_btnstb(mus_btnstb), .kj_stb(kj_stb)
   );

   always #5 fclk = ~fclk;

   typedef struct {
      int          n;
      logic [55:0] by;
      logic [4:0]  stb;   // {kbd, x, y, btn, kj}
      logic [39:0] ko;
      logic [7:0]  mo;
   } vec_t;

   int nvec = 0;
   int nfail = 0;
   int c_kbd = 0, c_x = 0, c_y = 0, c_btn = 0, c_kj = 0, c_multi = 0;

   // Strobe cycle counters, sampled away from the active edge
   always @(negedge fclk) begin
      c_kbd <= c_kbd + int'(kbd_stb);
      c_x   <= c_x + int'(mus_xstb);
      c_y   <= c_y + int'(mus_ystb);
      c_btn <= c_btn + int'(mus_btnstb);
      c_kj  <= c_kj + int'(kj_stb);
      if ((int'(kbd_stb) + int'(mus_xstb) + int'(mus_ystb) + int'(mus_btnstb) + int'(kj_stb)) > 1)
         c_multi <= c_multi + 1;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_bits(input logic [7:0] b, input int nbits);
      for (int i = 7; i > 7 - nbits; i--) begin
         spido = b[i];
         #HALF;
         spick = 1'b1;
         #HALF;
         spick = 1'b0;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_bits(b, 8);
   endtask

   function automatic vec_t mk(input int n, input logic [55:0] by, input logic [4:0] stb,
                               input logic [39:0] ko, input logic [7:0] mo);
      vec_t v;
      v.n = n; v.by = by; v.stb = stb; v.ko = ko; v.mo = mo;
      return v;
   endfunction

   task automatic apply_vec(input vec_t v, input int idx);
      int b_kbd, b_x, b_y, b_btn, b_kj;
      logic [7:0] bb;
      b_kbd = c_kbd; b_x = c_x; b_y = c_y; b_btn = c_btn; b_kj = c_kj;
      spics_n = 1'b0;
      #60;
      for (int i = 0; i < v.n; i++) begin
         bb = v.by[55-8*i -: 8];
         send_byte(bb);
      end
      #100;
      spics_n = 1'b1;
      #150;
      chk($sformatf("v%0d kbd_stb", idx), 64'(c_kbd - b_kbd), 64'(v.stb[4]));
      chk($sformatf("v%0d mus_xstb", idx), 64'(c_x - b_x), 64'(v.stb[3]));
      chk($sformatf("v%0d mus_ystb", idx), 64'(c_y - b_y), 64'(v.stb[2]));
      chk($sformatf("v%0d mus_btnstb", idx), 64'(c_btn - b_btn), 64'(v.stb[1]));
      chk($sformatf("v%0d kj_stb", idx), 64'(c_kj - b_kj), 64'(v.stb[0]));
      chk($sformatf("v%0d kbd_out", idx), 64'(kbd_out), 64'(v.ko));
      chk($sformatf("v%0d mus_out", idx), 64'(mus_out), 64'(v.mo));
   endtask

   vec_t tbl[9];

   initial begin
      int base, lat;
      bit found;
      logic [7:0] lb;

      tbl[0] = mk(6, 56'h10_01_02_04_08_10_00, 5'b10000, 40'h1008040201, 8'hFF);
      tbl[1] = mk(3, 56'h21_7F_55_00_00_00_00, 5'b00100, 40'h1008040201, 8'h7F);
      tbl[2] = mk(4, 56'h10_01_02_03_00_00_00, 5'b00000, 40'h1008040201, 8'h7F);
      tbl[3] = mk(6, 56'h10_AA_BB_CC_DD_EE_00, 5'b10000, 40'hEEDDCCBBAA, 8'h7F);
      tbl[4] = mk(2, 56'h20_A5_00_00_00_00_00, 5'b01000, 40'hEEDDCCBBAA, 8'hA5);
      tbl[5] = KJ ? mk(2, 56'h30_1B_00_00_00_00_00, 5'b00001, 40'hEEDDCCBBAA, 8'h1B)
                  : mk(2, 56'h30_1B_00_00_00_00_00, 5'b00000, 40'hEEDDCCBBAA, 8'hA5);
      tbl[6] = mk(3, 56'h99_22_03_00_00_00_00, 5'b00000, 40'hEEDDCCBBAA, KJ ? 8'h1B : 8'hA5);
      tbl[7] = mk(2, 56'h22_03_00_00_00_00_00, 5'b00010, 40'hEEDDCCBBAA, 8'h03);
      tbl[8] = mk(2, 56'h40_12_00_00_00_00_00, 5'b00000, 40'hEEDDCCBBAA, 8'h03);

      rst_n = 1'b0; spics_n = 1'b1; spick = 1'b0; spido = 1'b0;
      #25;
      chk("reset kbd_out", 64'(kbd_out), 64'h0);
      chk("reset mus_out", 64'(mus_out), 64'hFF);
      chk("reset strobes", 64'({kbd_stb, mus_xstb, mus_ystb, mus_btnstb, kj_stb}), 64'h0);
      rst_n = 1'b1;
      #100;

      for (int i = 0; i < 9; i++)
         apply_vec(tbl[i], i);

      // CS rises mid-byte: partial bits must not misalign the next frame
      base = c_x;
      spics_n = 1'b0;
      #60;
      send_byte(8'h20);
      send_bits(8'hFF, 4);
      #60;
      spics_n = 1'b1;
      #150;
      chk("partial byte no strobe", 64'(c_x - base), 64'h0);
      apply_vec(mk(2, 56'h20_5A_00_00_00_00_00, 5'b01000, 40'hEEDDCCBBAA, 8'h5A), 9);

      // Latency: spick driven on negedge, so the next posedge is the first sampling edge
      @(negedge fclk);
      spics_n = 1'b0;
      repeat (6) @(negedge fclk);
      for (int k = 0; k < 2; k++) begin
         lb = (k == 0) ? 8'h20 : 8'h3C;
         for (int i = 7; i >= 0; i--) begin
            @(negedge fclk);
            spido = lb[i];
            repeat (4) @(negedge fclk);
            spick = 1'b1;
            if (k == 1 && i == 0) begin
               @(posedge fclk);
               lat = 0;
               found = 1'b0;
               for (int n = 1; n <= 12 && !found; n++) begin
                  @(posedge fclk);
                  #1;
                  if (mus_xstb) begin
                     lat = n;
                     found = 1'b1;
                  end
               end
               chk("strobe latency", 64'(lat), 64'd5);
            end else begin
               repeat (4) @(negedge fclk);
            end
            @(negedge fclk);
            spick = 1'b0;
         end
      end
      repeat (10) @(negedge fclk);
      spics_n = 1'b1;
      repeat (15) @(negedge fclk);
      chk("latency mus_out", 64'(mus_out), 64'h3C);

      // Reset pulse during byte 2 of a keyboard frame
      base = c_kbd + c_x + c_y + c_btn + c_kj;
      spics_n = 1'b0;
      #60;
      send_byte(8'h10);
      send_byte(8'h01);
      send_bits(8'h02, 4);
      rst_n = 1'b0;
      #3;
      chk("midreset kbd_out", 64'(kbd_out), 64'h0);
      chk("midreset mus_out", 64'(mus_out), 64'hFF);
      #20;
      rst_n = 1'b1;
      spido = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #HALF; spick = 1'b1; #HALF; spick = 1'b0;
      end
      send_byte(8'h04);
      send_byte(8'h08);
      send_byte(8'h10);
      #100;
      spics_n = 1'b1;
      #150;
      chk("midreset no strobe", 64'(c_kbd + c_x + c_y + c_btn + c_kj - base), 64'h0);
      chk("midreset kbd_out hold", 64'(kbd_out), 64'h0);
      apply_vec(mk(6, 56'h10_11_22_33_44_55_00, 5'b10000, 40'h5544332211, 8'hFF), 10);

      chk("single strobe per cycle", 64'(c_multi), 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

// File: doc/kbdmus_spi_rx.md
KBDMUS_SPI_RX -- requirements
Module: kbdmus_spi_rx

Interface
REQ-001 SHALL have port fclk, input, 1 bit: system clock, the only clock; all logic on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port spics_n, input, 1 bit: SPI chip select from AVR, active-low, asynchronous to fclk.
REQ-004 SHALL have port spick, input, 1 bit: SPI clock, mode 0, data sampled on its rising edge, asynchronous to fclk.
REQ-005 SHALL have port spido, input, 1 bit: SPI MOSI, MSB first.
REQ-006 SHALL have port kbd_out, output, 40 bits: keyboard matrix bits, registered.
REQ-007 SHALL have port kbd_stb, output, 1 bit: one-cycle strobe, kbd_out newly valid.
REQ-008 SHALL have port mus_out, output, 8 bits: mouse or joystick data byte, registered.
REQ-009 SHALL have ports mus_xstb, mus_ystb, mus_btnstb and kj_stb, each output, 1 bit: one-cycle strobes qualifying mus_out.

Function
REQ-010 SHALL pass spics_n, spick and spido each through a 2-flop synchronizer, then one edge-history flop; spick rising edge = synced 0->1 while synced spics_n low.
REQ-011 SHALL shift the synced spido into an 8-bit shift register on each spick rising edge, MSB first; a 3-bit counter SHALL mark byte completion at the 8th edge.
REQ-012 SHALL raise an internal byte-ready for exactly one fclk cycle per completed byte, the cycle after the 8th edge is detected.
REQ-013 SHALL require spick high and low phases of at least 3 fclk cycles each; no behaviour is guaranteed for faster spick.
REQ-014 SHALL use FSM states IDLE, CMD, KBD, MUS, SKIP.
REQ-015 IDLE->CMD on synced spics_n falling; any state->IDLE on synced spics_n high, with bit counter cleared.
REQ-016 In CMD, the first byte SHALL be the command: 0x10->KBD (byte index 0); 0x20/0x21/0x22/0x30->MUS with target X/Y/BTN/KJ; any other value->SKIP.
REQ-017 In KBD, data byte k (k=0..4) SHALL go to shadow bits [8k+7:8k]; on byte 4, kbd_out SHALL load the full shadow and kbd_stb SHALL be high in the same cycle kbd_out first shows the new value; then ->SKIP.
REQ-018 In MUS, the first data byte SHALL load mus_out and pulse the matching strobe in the same cycle; then ->SKIP.
REQ-019 SKIP SHALL ignore all further bytes until spics_n deasserts.
REQ-020 spics_n rising mid-byte SHALL discard the partial byte; mid-keyboard frame (fewer than 5 bytes) SHALL discard the shadow with no kbd_stb and kbd_out unchanged.
REQ-021 At most one strobe SHALL be high in any cycle; every strobe SHALL last exactly one cycle.
REQ-022 Strobe latency SHALL be 5 fclk cycles from the fclk edge that first samples the final spick rising edge at the pin, and constant.
REQ-023 kbd_out and mus_out SHALL hold their value between strobes.

Reset
REQ-024 rst_n low SHALL asynchronously set: FSM IDLE, bit counter 0, shift and shadow registers 0, kbd_out 40'h0, mus_out 8'hFF, all strobes 0, synchronizers idle (spics_n=1, spick=0).
REQ-025 Reset released mid-transfer SHALL not produce a strobe until a fresh spics_n falling edge and complete command is received.

Configuration
REQ-026 Macro KBDMUS_RX_KJOY_EN SHALL control joystick support.
REQ-027 With KBDMUS_RX_KJOY_EN defined, command 0x30 SHALL behave per REQ-016/REQ-018 via kj_stb.
REQ-028 Without KBDMUS_RX_KJOY_EN, 0x30 SHALL be treated as an unknown command (->SKIP), and kj_stb SHALL be tied to 0.

Verification
REQ-029 Frame CS low, 0x10, 0x01,0x02,0x04,0x08,0x10, CS high -> single kbd_stb; kbd_out=40'h1008040201.
REQ-030 Frame 0x21, 0x7F -> single mus_ystb, mus_out=0x7F; no other strobe; a trailing extra byte 0x55 is ignored.
REQ-031 Keyboard frame aborted after 3 data bytes by CS high -> no kbd_stb, kbd_out keeps its previous value; next full frame is accepted.
REQ-032 Frame 0x30, 0x1B -> with macro: kj_stb, mus_out=0x1B; without: no strobe, mus_out unchanged.
REQ-033 rst_n pulsed low during byte 2 of a keyboard frame -> outputs at reset values immediately; no strobe for the remainder of that frame.
REQ-034 Unknown command 0x99 followed by 0x22, 0x03 in the same CS window -> no strobe; the same bytes sent in a new window after CS re-assert -> mus_btnstb, mus_out=0x03.
